// File: rtl/io_change_monitor.sv
// Watches a bus and records every change as a timestamped event in a first-word-fall-through FIFO.
// A cycle-count watchdog can freeze recording after TIMEOUT enabled cycles.
module io_change_monitor #(
  parameter int WIDTH    = 5,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int TIMEOUT  = 100
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic [WIDTH-1:0]           i_Watch,
  output logic                       o_Evt_Valid,
  input  logic                       i_Evt_Ready,
  output logic [WIDTH-1:0]           o_Evt_Data,
  output logic [TS_WIDTH-1:0]        o_Evt_Time,
  output logic                       o_Evt_Lost,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic [7:0]                 o_Drop_Count,
  output logic                       o_Timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + TS_WIDTH + 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(TIMEOUT - 1);

  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TS_WIDTH-1:0] time_q, time_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic                lost_q, lost_d;
  logic [7:0]          drop_q, drop_d;
  logic                timeout_q, timeout_d;

  logic active_s, change_s, valid_s, full_s, pop_s, push_s, drop_s, wd_hit_s;
  logic [EW-1:0] head_s;

  assign active_s = i_Enable && !timeout_q;
  assign change_s = active_s && (i_Watch != prev_q);
  assign valid_s  = (count_q != CW'(0));
  assign full_s   = (count_q == CW'(DEPTH));
  assign pop_s    = valid_s && i_Evt_Ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s   = change_s && (!full_s || pop_s);
  assign drop_s   = change_s && full_s && !pop_s;
  assign wd_hit_s = WD_EN && active_s && (time_q == TS_LAST);
  assign head_s   = mem_q[rd_ptr_q];

  // Next-state computation for pointers, counters, timestamp and flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    time_d    = time_q;
    prev_d    = prev_q;
    lost_d    = lost_q;
    drop_d    = drop_q;
    timeout_d = timeout_q;

    if (active_s) begin
      time_d = time_q + TS_WIDTH'(1);
      prev_d = i_Watch;
    end else begin
      time_d = time_q;
      prev_d = prev_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s) begin
      lost_d = 1'b0;
    end else if (drop_s) begin
      lost_d = 1'b1;
    end else begin
      lost_d = lost_q;
    end

    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    if (wd_hit_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      time_q    <= '0;
      prev_q    <= '0;
      lost_q    <= 1'b0;
      drop_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      time_q    <= time_d;
      prev_q    <= prev_d;
      lost_q    <= lost_d;
      drop_q    <= drop_d;
      timeout_q <= timeout_d;
    end
  end

  // Event storage; contents become stale on reset because the pointers clear.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && push_s) begin
      mem_q[wr_ptr_q] <= {i_Watch, time_q, lost_q};
    end
  end

  assign o_Evt_Valid  = valid_s;
  assign o_Evt_Data   = valid_s ? head_s[EW-1 -: WIDTH]  : '0;
  assign o_Evt_Time   = valid_s ? head_s[TS_WIDTH:1]     : '0;
  assign o_Evt_Lost   = valid_s ? head_s[0]              : 1'b0;
  assign o_Count      = count_q;
  assign o_Drop_Count = drop_q;
  assign o_Timeout    = timeout_q;

endmodule

// File: tb/tb_io_change_monitor.sv
// Scoreboard bench for io_change_monitor: stimulus pushes expected events, a negedge monitor checks each accepted head.
module tb_io_change_monitor;

  typedef struct packed {
    logic [4:0]  data;
    logic [15:0] ts;
    logic        lost;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  watch = 5'd0;
  logic        ready = 1'b0;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic [15:0] evt_time;
  logic        evt_lost;
  logic [3:0]  count;
  logic [7:0]  drop_count;
  logic        timeout;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  io_change_monitor #(.WIDTH(5), .DEPTH(8), .TS_WIDTH(16), .TIMEOUT(100)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Watch(watch),
    .o_Evt_Valid(evt_valid), .i_Evt_Ready(ready), .o_Evt_Data(evt_data),
    .o_Evt_Time(evt_time), .o_Evt_Lost(evt_lost), .o_Count(count),
    .o_Drop_Count(drop_count), .o_Timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_ev(input logic [4:0] d, input logic [15:0] t, input logic l);
    ev_t e;
    e.data = d;
    e.ts   = t;
    e.lost = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every head accepted at the coming edge is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && evt_valid && ready) begin
      ev_t got;
      ev_t want;
      got = {evt_data, evt_time, evt_lost};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got data=%0d time=%0d lost=%0d, expected none",
                 evt_data, evt_time, evt_lost);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          n_fail++;
          $display("FAIL event: got data=%0d time=%0d lost=%0d expected data=%0d time=%0d lost=%0d",
                   got.data, got.ts, got.lost, want.data, want.ts, want.lost);
        end
      end
    end
  end

  initial begin
    int budget;

    // Reset and idle bus
    en = 1'b1; watch = 5'd0; ready = 1'b1;
    do_reset();
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_count", int'(count), 0);
    step(20);
    chk("idle_valid", int'(evt_valid), 0);
    chk("idle_count", int'(count), 0);
    chk("idle_drop", int'(drop_count), 0);

    // Single change at time 3
    do_reset();
    step(3);
    watch = 5'b00011;
    expect_ev(5'd3, 16'd3, 1'b0);
    chk("single_pre_valid", int'(evt_valid), 0);
    step(1);
    chk("single_valid", int'(evt_valid), 1);
    chk("single_count", int'(count), 1);
    step(1);
    chk("single_empty", int'(evt_valid), 0);

    // Overflow: 10 changes into 8 entries, then lost flag on next event
    ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      watch = 5'(i);
      if (i <= 8) expect_ev(5'(i), 16'(i - 1), 1'b0);
      step(1);
    end
    chk("ovf_count", int'(count), 8);
    chk("ovf_drop", int'(drop_count), 2);
    en = 1'b0; ready = 1'b1;
    step(8);
    chk("ovf_drained", int'(count), 0);
    en = 1'b1;
    step(10);
    watch = 5'd11;
    expect_ev(5'd11, 16'd20, 1'b1);
    step(1);
    watch = 5'd12;
    expect_ev(5'd12, 16'd21, 1'b0);
    step(4);
    chk("ovf_final_count", int'(count), 0);
    chk("ovf_final_drop", int'(drop_count), 2);

    // Full FIFO with simultaneous push and pop
    ready = 1'b0; watch = 5'd0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      watch = 5'(i);
      expect_ev(5'(i), 16'(i - 1), 1'b0);
      step(1);
    end
    chk("full_count", int'(count), 8);
    watch = 5'd9; ready = 1'b1;
    expect_ev(5'd9, 16'd8, 1'b0);
    step(1);
    chk("full_pushpop_count", int'(count), 8);
    chk("full_pushpop_drop", int'(drop_count), 0);
    step(8);
    chk("full_drained", int'(count), 0);

    // Watchdog
    ready = 1'b0; watch = 5'd0;
    do_reset();
    step(99);
    chk("wd_before", int'(timeout), 0);
    watch = 5'd7;
    expect_ev(5'd7, 16'd99, 1'b0);
    step(1);
    chk("wd_set", int'(timeout), 1);
    watch = 5'd8;
    step(5);
    chk("wd_ignored_count", int'(count), 1);
    chk("wd_sticky", int'(timeout), 1);
    chk("wd_time_frozen", int'(dut.time_q), 100);
    ready = 1'b1;
    step(2);
    chk("wd_drained", int'(count), 0);

    // Reset in the middle of draining
    ready = 1'b0; watch = 5'd0;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      watch = 5'(i);
      expect_ev(5'(i), 16'(i - 1), 1'b0);
      step(1);
    end
    ready = 1'b1;
    step(1);
    chk("midpop_count", int'(count), 2);
    do_reset();
    chk("midpop_valid", int'(evt_valid), 0);
    chk("midpop_count0", int'(count), 0);
    chk("midpop_timeout", int'(timeout), 0);
    expect_ev(5'd3, 16'd0, 1'b0);
    step(1);
    chk("post_reset_valid", int'(evt_valid), 1);
    step(1);

    // Wait (bounded) for the scoreboard to empty
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
